// File: rtl/wide_add_pkg.sv
// wide_add_pkg
//   Shared constants and elaboration helpers for the lane-sliced wide adder.
//   - ADD / SUB   : encodings of the 'sub' operation select
//   - num_stages  : pipeline depth S for a given operand and lane width
//   - cfg_ok      : true when WIDTH splits into a whole number (>= 1) of lanes
`timescale 1ns/1ps
package wide_add_pkg;

  localparam logic ADD = 1'b0;
  localparam logic SUB = 1'b1;

  function automatic int num_stages(input int width, input int lane_w);
    return (lane_w > 0) ? (width / lane_w) : 1;
  endfunction

  function automatic bit cfg_ok(input int width, input int lane_w);
    return (lane_w > 0) && ((width % lane_w) == 0) && ((width / lane_w) >= 1);
  endfunction

endpackage

// File: rtl/wide_add_lane.sv
// wide_add_lane
//   One pipeline stage of the wide adder. Adds lane IDX of the two skewed
//   operand buses plus the carry from the previous stage, then registers the
//   result lane, the carry, a valid bit and the forwarded operand/result buses.
//   Ports:
//     clk, rst          : clock, synchronous active-high reset
//     advance           : global pipeline enable; all registers hold when low
//     up_valid/up_carry : valid bit and carry from the previous stage
//     up_op1/up_op2     : skewed operand buses (op2 already inverted for sub)
//     up_res            : result lanes completed by earlier stages
//     valid/carry       : registered valid bit and lane carry-out
//     op1/op2           : forwarded operand buses, consumed lanes cleared
//     res               : result bus with lane IDX filled in
`timescale 1ns/1ps
module wide_add_lane #(
  parameter int WIDTH  = 256,
  parameter int LANE_W = 64,
  parameter int IDX    = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             advance,
  input  logic             up_valid,
  input  logic             up_carry,
  input  logic [WIDTH-1:0] up_op1,
  input  logic [WIDTH-1:0] up_op2,
  input  logic [WIDTH-1:0] up_res,
  output logic             valid,
  output logic             carry,
  output logic [WIDTH-1:0] op1,
  output logic [WIDTH-1:0] op2,
  output logic [WIDTH-1:0] res
);

  localparam int LO = IDX * LANE_W;

  // Only lanes above this one still need to travel down the pipeline; the
  // consumed lanes are cleared so they do not need to be kept.
  localparam logic [WIDTH-1:0] UPPER_MASK = {WIDTH{1'b1}} << ((IDX + 1) * LANE_W);

  logic [LANE_W:0]  lane_sum;
  logic [WIDTH-1:0] res_next;

  assign lane_sum = {1'b0, up_op1[LO +: LANE_W]}
                  + {1'b0, up_op2[LO +: LANE_W]}
                  + {{LANE_W{1'b0}}, up_carry};

  always_comb begin
    res_next = up_res;
    res_next[LO +: LANE_W] = lane_sum[LANE_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      carry <= 1'b0;
      op1   <= '0;
      op2   <= '0;
      res   <= '0;
    end else if (advance) begin
      valid <= up_valid;
      carry <= lane_sum[LANE_W];
      op1   <= up_op1 & UPPER_MASK;
      op2   <= up_op2 & UPPER_MASK;
      res   <= res_next;
    end
  end

endmodule

// File: rtl/wide_add_pipe.sv
// wide_add_pipe
//   Handshaked WIDTH-bit adder/subtractor built from S = WIDTH/LANE_W carry
//   pipeline stages. Beats whose en1+en2 (truncated) is not all ones are
//   consumed without producing a result and counted in drop_cnt.
//   Ports:
//     clk, rst            : clock, synchronous active-high reset
//     in_valid/in_ready   : operand handshake (in_ready = pipeline advance)
//     op1, op2, sub       : operands; sub=1 computes op1-op2
//     en1, en2            : per-beat qualifier inputs
//     out_valid/out_ready : result handshake
//     res, carry_out      : registered result and top-lane carry (1 = no borrow)
//     drop_cnt            : saturating count of filtered beats
`timescale 1ns/1ps
module wide_add_pipe
  import wide_add_pkg::*;
#(
  parameter int WIDTH  = 256,
  parameter int LANE_W = 64,
  parameter int EN_W   = 8,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic             sub,
  input  logic [EN_W-1:0]  en1,
  input  logic [EN_W-1:0]  en2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic             carry_out,
  output logic [CNT_W-1:0] drop_cnt
);

  localparam int S = num_stages(WIDTH, LANE_W);

  if (!cfg_ok(WIDTH, LANE_W)) begin : g_bad_cfg
    $error("wide_add_pipe: WIDTH must be a positive multiple of LANE_W");
  end

  logic            advance;
  logic            gate;
  logic [EN_W-1:0] en_sum;

  // Element k feeds stage k; element S is the output register set.
  logic             valid_bus [S+1];
  logic             carry_bus [S+1];
  logic [WIDTH-1:0] op1_bus   [S+1];
  logic [WIDTH-1:0] op2_bus   [S+1];
  logic [WIDTH-1:0] res_bus   [S+1];

  // The qualifier sum is deliberately truncated to EN_W bits before reduction.
  assign en_sum = en1 + en2;
  assign gate   = &en_sum;

  // Single global stall: everything moves only when the output slot is free
  // or being drained this cycle.
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  // Subtraction is op1 + ~op2 + 1; a filtered beat enters as a bubble.
  assign valid_bus[0] = in_valid && gate;
  assign carry_bus[0] = (sub == SUB);
  assign op1_bus[0]   = op1;
  assign op2_bus[0]   = (sub == SUB) ? ~op2 : op2;
  assign res_bus[0]   = '0;

  for (genvar k = 0; k < S; k++) begin : g_lane
    wide_add_lane #(
      .WIDTH  (WIDTH),
      .LANE_W (LANE_W),
      .IDX    (k)
    ) u_lane (
      .clk      (clk),
      .rst      (rst),
      .advance  (advance),
      .up_valid (valid_bus[k]),
      .up_carry (carry_bus[k]),
      .up_op1   (op1_bus[k]),
      .up_op2   (op2_bus[k]),
      .up_res   (res_bus[k]),
      .valid    (valid_bus[k+1]),
      .carry    (carry_bus[k+1]),
      .op1      (op1_bus[k+1]),
      .op2      (op2_bus[k+1]),
      .res      (res_bus[k+1])
    );
  end

  assign out_valid = valid_bus[S];
  assign carry_out = carry_bus[S];
  assign res       = res_bus[S];

  // The last stage has no operand lanes left to forward.
  logic unused_tail;
  assign unused_tail = &{1'b0, op1_bus[S], op2_bus[S]};

  // Count filtered transfers only; saturate instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt <= '0;
    end else if (in_valid && in_ready && !gate && (drop_cnt != '1)) begin
      drop_cnt <= drop_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_wide_add_pipe.sv
// tb_wide_add_pipe
//   Directed self-checking bench for wide_add_pipe with default parameters
//   (WIDTH=256, LANE_W=64, S=4, EN_W=8, CNT_W=16).
`timescale 1ns/1ps
module tb_wide_add_pipe;

  localparam int WIDTH  = 256;
  localparam int LANE_W = 64;
  localparam int EN_W   = 8;
  localparam int CNT_W  = 16;
  localparam logic [63:0] F64 = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             s;
    logic [WIDTH-1:0] r;
    logic             c;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] op1;
  logic [WIDTH-1:0] op2;
  logic             sub;
  logic [EN_W-1:0]  en1;
  logic [EN_W-1:0]  en2;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] res;
  logic             carry_out;
  logic [CNT_W-1:0] drop_cnt;

  int   checks = 0;
  int   errors = 0;
  vec_t vec [8];

  always #5 clk = ~clk;

  wide_add_pipe #(
    .WIDTH  (WIDTH),
    .LANE_W (LANE_W),
    .EN_W   (EN_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op1       (op1),
    .op2       (op2),
    .sub       (sub),
    .en1       (en1),
    .en2       (en2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res       (res),
    .carry_out (carry_out),
    .drop_cnt  (drop_cnt)
  );

  task automatic checkOutput(input string tag, input logic [WIDTH-1:0] actual,
                             input logic [WIDTH-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One gated beat with the sink always ready; reports result and latency
  // in edges counted from the capturing edge (0 if it never appears).
  task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                               input logic s, output logic [WIDTH-1:0] got_res,
                               output logic got_carry, output int got_lat);
    bit got;
    got = 0;
    got_lat = 0;
    got_res = '0;
    got_carry = 1'b0;
    op1 = a;
    op2 = b;
    sub = s;
    en1 = 8'h80;
    en2 = 8'h7F;
    out_ready = 1'b1;
    in_valid = 1'b1;
    for (int n = 1; n <= 20 && !got; n++) begin
      step();
      if (n == 1) in_valid = 1'b0;
      if (out_valid) begin
        got = 1;
        got_lat = n;
        got_res = res;
        got_carry = carry_out;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [WIDTH-1:0] r;
    logic             c;
    int               lat;
    int               sent;
    int               recv;
    bit               found;

    vec[0] = '{a: {64'h0, 64'h0, 64'h0, F64}, b: {64'h0, 64'h0, 64'h0, 64'h1}, s: 1'b0,
               r: {64'h0, 64'h0, 64'h1, 64'h0}, c: 1'b0};
    vec[1] = '{a: {64'h0, 64'h0, F64, F64}, b: {64'h0, 64'h0, 64'h0, 64'h1}, s: 1'b0,
               r: {64'h0, 64'h1, 64'h0, 64'h0}, c: 1'b0};
    vec[2] = '{a: {64'h0, 64'h0, 64'h1, 64'h0}, b: {64'h0, 64'h0, 64'h0, 64'h1}, s: 1'b1,
               r: {64'h0, 64'h0, 64'h0, F64}, c: 1'b1};
    vec[3] = '{a: {64'h8000_0000_0000_0000, 64'h0, 64'h0, 64'h0},
               b: {64'h8000_0000_0000_0000, 64'h0, 64'h0, 64'h0}, s: 1'b0,
               r: {64'h0, 64'h0, 64'h0, 64'h0}, c: 1'b1};
    vec[4] = '{a: {64'h0, 64'h0, 64'h0, 64'h0}, b: {64'h0, 64'h0, 64'h0, 64'h1}, s: 1'b1,
               r: {F64, F64, F64, F64}, c: 1'b0};
    vec[5] = '{a: {64'h1, 64'h2, 64'h3, 64'h4}, b: {64'h10, 64'h20, 64'h30, 64'h40}, s: 1'b0,
               r: {64'h11, 64'h22, 64'h33, 64'h44}, c: 1'b0};
    vec[6] = '{a: {64'h11, 64'h22, 64'h33, 64'h44}, b: {64'h1, 64'h2, 64'h3, 64'h4}, s: 1'b1,
               r: {64'h10, 64'h20, 64'h30, 64'h40}, c: 1'b1};
    vec[7] = '{a: {F64, F64, F64, F64}, b: {F64, F64, F64, F64}, s: 1'b0,
               r: {F64, F64, F64, 64'hFFFF_FFFF_FFFF_FFFE}, c: 1'b1};

    rst = 1'b1;
    in_valid = 1'b0;
    op1 = '0;
    op2 = '0;
    sub = 1'b0;
    en1 = '0;
    en2 = '0;
    out_ready = 1'b1;

    // Reset, then idle.
    repeat (3) step();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      checkOutput("idle_in_ready", WIDTH'(in_ready), WIDTH'(1));
      checkOutput("idle_out_valid", WIDTH'(out_valid), WIDTH'(0));
      checkOutput("idle_res", res, '0);
      checkOutput("idle_drop_cnt", WIDTH'(drop_cnt), WIDTH'(0));
    end
    checkOutput("idle_carry", WIDTH'(carry_out), WIDTH'(0));

    // Carry ripple across all four lanes.
    $display("[TB] carry ripple");
    applyStimulus({WIDTH{1'b1}}, WIDTH'(1), 1'b0, r, c, lat);
    checkOutput("ripple_latency", WIDTH'(lat), WIDTH'(4));
    checkOutput("ripple_res", r, '0);
    checkOutput("ripple_carry", WIDTH'(c), WIDTH'(1));

    // Subtraction with and without borrow.
    $display("[TB] subtraction");
    applyStimulus(WIDTH'(5), WIDTH'(7), 1'b1, r, c, lat);
    checkOutput("sub_borrow_latency", WIDTH'(lat), WIDTH'(4));
    checkOutput("sub_borrow_res", r, {{(WIDTH-1){1'b1}}, 1'b0});
    checkOutput("sub_borrow_carry", WIDTH'(c), WIDTH'(0));
    applyStimulus(WIDTH'(7), WIDTH'(5), 1'b1, r, c, lat);
    checkOutput("sub_noborrow_res", r, WIDTH'(2));
    checkOutput("sub_noborrow_carry", WIDTH'(c), WIDTH'(1));

    // A single filtered beat.
    $display("[TB] filtered beat");
    step();
    en1 = 8'h01;
    en2 = 8'h01;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    checkOutput("drop_one", WIDTH'(drop_cnt), WIDTH'(1));
    for (int i = 0; i < 6; i++) begin
      step();
      checkOutput("drop_no_out", WIDTH'(out_valid), WIDTH'(0));
    end

    // Stalled output: filtered beat offered while in_ready is low.
    $display("[TB] stall with filtered beat offered");
    out_ready = 1'b0;
    op1 = vec[5].a;
    op2 = vec[5].b;
    sub = vec[5].s;
    en1 = 8'h80;
    en2 = 8'h7F;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (out_valid) found = 1;
      else step();
    end
    checkOutput("stall_reached", WIDTH'(found), WIDTH'(1));
    en1 = 8'h01;
    en2 = 8'h01;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checkOutput("stall1_in_ready", WIDTH'(in_ready), WIDTH'(0));
      checkOutput("stall1_out_valid", WIDTH'(out_valid), WIDTH'(1));
      checkOutput("stall1_res", res, vec[5].r);
      checkOutput("stall1_drop_cnt", WIDTH'(drop_cnt), WIDTH'(1));
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    #1;
    checkOutput("stall1_release", WIDTH'(in_ready), WIDTH'(1));
    step();
    checkOutput("stall1_drained", WIDTH'(out_valid), WIDTH'(0));
    checkOutput("stall1_drop_after", WIDTH'(drop_cnt), WIDTH'(1));

    // Eight back-to-back beats, sink stalled on cycles 6..9.
    $display("[TB] back-to-back with stall");
    sent = 0;
    recv = 0;
    en1 = 8'h80;
    en2 = 8'h7F;
    for (int cyc = 0; cyc < 60 && recv < 8; cyc++) begin
      out_ready = !(cyc >= 6 && cyc <= 9);
      if (sent < 8) begin
        in_valid = 1'b1;
        op1 = vec[sent].a;
        op2 = vec[sent].b;
        sub = vec[sent].s;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (cyc >= 6 && cyc <= 9) begin
        checkOutput("b2b_stall_in_ready", WIDTH'(in_ready), WIDTH'(0));
        checkOutput("b2b_stall_out_valid", WIDTH'(out_valid), WIDTH'(1));
        checkOutput("b2b_stall_res", res, vec[recv].r);
      end
      if (out_valid && out_ready) begin
        checkOutput($sformatf("b2b_res%0d", recv), res, vec[recv].r);
        checkOutput($sformatf("b2b_carry%0d", recv), WIDTH'(carry_out), WIDTH'(vec[recv].c));
        recv++;
      end
      if (in_valid && in_ready) sent++;
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    checkOutput("b2b_sent", WIDTH'(sent), WIDTH'(8));
    checkOutput("b2b_recv", WIDTH'(recv), WIDTH'(8));
    for (int i = 0; i < 5; i++) begin
      step();
      checkOutput("b2b_no_dup", WIDTH'(out_valid), WIDTH'(0));
    end

    // Saturation of the drop counter (2^16+3 filtered beats in total).
    $display("[TB] drop counter saturation");
    en1 = 8'h01;
    en2 = 8'h01;
    in_valid = 1'b1;
    repeat (65533) step();
    checkOutput("sat_fffe", WIDTH'(drop_cnt), WIDTH'(16'hFFFE));
    step();
    checkOutput("sat_ffff", WIDTH'(drop_cnt), WIDTH'(16'hFFFF));
    repeat (4) step();
    checkOutput("sat_hold", WIDTH'(drop_cnt), WIDTH'(16'hFFFF));
    in_valid = 1'b0;

    // Reset pulse with three beats in flight and a filtered beat offered.
    $display("[TB] reset flush");
    en1 = 8'h80;
    en2 = 8'h7F;
    for (int i = 0; i < 3; i++) begin
      op1 = vec[i].a;
      op2 = vec[i].b;
      sub = vec[i].s;
      in_valid = 1'b1;
      step();
    end
    en1 = 8'h01;
    en2 = 8'h01;
    rst = 1'b1;
    step();
    rst = 1'b0;
    in_valid = 1'b0;
    checkOutput("flush_drop_cnt", WIDTH'(drop_cnt), WIDTH'(0));
    checkOutput("flush_in_ready", WIDTH'(in_ready), WIDTH'(1));
    for (int i = 0; i < 8; i++) begin
      checkOutput("flush_no_out", WIDTH'(out_valid), WIDTH'(0));
      step();
    end
    applyStimulus(vec[6].a, vec[6].b, vec[6].s, r, c, lat);
    checkOutput("fresh_latency", WIDTH'(lat), WIDTH'(4));
    checkOutput("fresh_res", r, vec[6].r);
    checkOutput("fresh_carry", WIDTH'(c), WIDTH'(vec[6].c));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
